ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter MASTERS, default 2, number of bus masters (2..8).
REQ-002 Parameter DEFAULT_MASTER, default 0, master parked on the bus when no requests are pending.
REQ-003 Parameter MAX_HOLD, default 16, maximum consecutive address-phase transfers one master may hold while another master requests.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 hbusreq  input  MASTERS  per-master bus request.
REQ-008 hlock  input  MASTERS  per-master locked-transfer request.
REQ-009 htrans  input  2  HTRANS of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-010 hburst  input  3  HBURST of the current address-phase owner (SINGLE=0).
REQ-011 hready  input  1  bus HREADY from the slave mux.
REQ-012 hgrant  output  MASTERS  one-hot grant, registered.
REQ-013 hmaster  output  clog2(MASTERS)  address-phase owner index, registered.
REQ-014 hmaster_data  output  clog2(MASTERS)  data-phase owner index, registered.
REQ-015 hmastlock  output  1  current address phase is locked, registered.

Function
REQ-016 hgrant SHALL always be exactly one-hot, and never all-zero outside reset.
REQ-017 The arbitration point SHALL be a cycle where hready=1, the owner's hlock=0, and either htrans is IDLE, or htrans is NONSEQ with hburst=SINGLE, or the hold counter has reached MAX_HOLD.
REQ-018 At an arbitration point, the new grant SHALL be the first requesting master in round-robin order starting at (hmaster+1) mod MASTERS, wrapping past MASTERS-1 to 0.
REQ-019 If no master requests at an arbitration point, the grant SHALL go to DEFAULT_MASTER (parking).
REQ-020 If only the current owner requests, the grant SHALL stay with the current owner and the hold counter SHALL reset to 0.
REQ-021 Outside an arbitration point, hgrant SHALL hold its value.
REQ-022 Grant change latency: hgrant SHALL update on the clock edge ending the arbitration cycle.
REQ-023 On each cycle with hready=1, hmaster SHALL load the index of hgrant, so the address phase follows the grant by one hready-qualified cycle.
REQ-024 On each cycle with hready=1, hmaster_data SHALL load hmaster.
REQ-025 When hready=0, hgrant, hmaster, hmaster_data and hmastlock SHALL hold their values, regardless of requests.
REQ-026 On each cycle with hready=1, hmastlock SHALL load hlock[granted index].
REQ-027 While the owner's hlock=1, no re-arbitration SHALL occur; MAX_HOLD SHALL be ignored and the hold counter SHALL saturate at MAX_HOLD.
REQ-028 Hold counter: it SHALL increment on hready=1 with htrans NONSEQ/SEQ while another master requests, clear on any grant change, and never wrap.
REQ-029 If the owner deasserts hbusreq mid-burst, the arbiter SHALL wait for the next arbitration point; it SHALL NOT truncate the burst.
REQ-030 If requests from several masters change in the same cycle as an arbitration point, the sampled values in that cycle SHALL decide the grant.
REQ-031 The FSM SHALL have three states. PARK: default master granted, no requests. OWN: requester granted. LOCK: owner locked. Transitions SHALL be PARK->OWN on any request, OWN->LOCK on hlock of the owner at hready, LOCK->OWN when hlock drops at hready, OWN->PARK at an arbitration point with no requests.

Reset
REQ-032 On rst=1 at a clock edge, hgrant SHALL be one-hot DEFAULT_MASTER, hmaster=hmaster_data=DEFAULT_MASTER, hmastlock=0, hold counter=0 and state=PARK.
REQ-033 Reset asserted mid-burst or mid-lock SHALL override all other behaviour on the same edge.

Structure
REQ-034 The HTRANS/HBURST encodings and the FSM state encodings SHALL live in the shared AHB defines package alongside the existing core defines.
REQ-035 Round-robin next-master selection SHALL be one combinational sub-module, ahb_rr_pick (inputs: request vector, last index; output: index, valid).

Verification
REQ-036 Reset with no requests: hbusreq=00 -> hgrant=01, hmaster=0, hmastlock=0 and state PARK for 10 cycles.
REQ-037 Round-robin: hbusreq=11 with single NONSEQ transfers and hready=1 -> grant alternates 01,10,01,10; hmaster lags hgrant by one cycle and hmaster_data lags hmaster by one cycle.
REQ-038 Burst hold: M1 in an INCR4 burst (NONSEQ,SEQ,SEQ,SEQ) with M0 requesting -> hgrant stays 10 until the last beat, then becomes 01.
REQ-039 Wait states: hready=0 for 3 cycles during a handover -> hgrant, hmaster and hmaster_data are frozen, then advance once hready=1.
REQ-040 Lock and starvation limit: M0 holds hlock=1 for 20 SEQ beats with M1 requesting -> no switch and hmastlock=1; with hlock=0 and MAX_HOLD=16, the grant moves to M1 after the 16th beat.
REQ-041 Reset mid-lock: rst=1 during LOCK state -> next cycle hgrant=01, hmastlock=0, state PARK.

Source files
------------

// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB defines: transfer/burst encodings and arbiter FSM states.
package ahb_arbiter_pkg;

    // HTRANS encodings
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    // HBURST encodings used by the arbiter and its users
    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

    // True for transfers that move data (NONSEQ or SEQ)
    function automatic logic f_trans_active(input htrans_e t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin picker: first requester after i_last, wrapping, ending at i_last.
module ahb_rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_last,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_valid
);

    localparam int unsigned IW = $clog2(N);

    // Candidate index at distance off (1..N) after last, modulo N
    function automatic logic [IW-1:0] f_cand(input logic [IW-1:0] last,
                                             input int unsigned   off);
        int unsigned s;
        s = 32'(last) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Scan from farthest to nearest so the nearest requester wins
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned i = N; i >= 1; i--) begin
            if (i_req[f_cand(i_last, i)]) begin
                o_idx   = f_cand(i_last, i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin with parking, burst/lock hold and hold limit.
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int unsigned MASTERS        = 2,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MASTERS-1:0]         hbusreq,
    input  logic [MASTERS-1:0]         hlock,
    input  logic [1:0]                 htrans,
    input  logic [2:0]                 hburst,
    input  logic                       hready,
    output logic [MASTERS-1:0]         hgrant,
    output logic [$clog2(MASTERS)-1:0] hmaster,
    output logic [$clog2(MASTERS)-1:0] hmaster_data,
    output logic                       hmastlock
);

    localparam int unsigned IW = $clog2(MASTERS);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0]      DEF_IDX   = IW'(DEFAULT_MASTER);
    localparam logic [MASTERS-1:0] DEF_GRANT = MASTERS'(1) << DEFAULT_MASTER;

    // Registered state and outputs
    logic [MASTERS-1:0] r_hgrant;
    logic [IW-1:0]      r_hmaster;
    logic [IW-1:0]      r_hmaster_data;
    logic               r_hmastlock;
    logic [CW-1:0]      r_hold_cnt;
    arb_state_e         r_state;

    // Combinational helpers
    htrans_e            w_htrans;
    logic [IW-1:0]      w_grant_idx;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_valid;
    logic [IW-1:0]      w_next_idx;
    logic               w_owner_lock;
    logic               w_others_req;
    logic               w_hold_full;
    logic               w_xfer_end;
    logic               w_arb_point;

    // Index of the currently granted master
    always_comb begin
        w_grant_idx = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (r_hgrant[i]) begin
                w_grant_idx = IW'(i);
            end
        end
    end

    ahb_rr_pick #(
        .N (MASTERS)
    ) u_pick (
        .i_req   (hbusreq),
        .i_last  (w_grant_idx),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Arbitration-point decode and next-owner selection
    always_comb begin
        w_htrans     = htrans_e'(htrans);
        w_owner_lock = hlock[w_grant_idx];
        w_others_req = |(hbusreq & ~r_hgrant);
        w_hold_full  = (r_hold_cnt == CW'(MAX_HOLD));
        w_xfer_end   = (w_htrans == HTRANS_IDLE) ||
                       ((w_htrans == HTRANS_NONSEQ) && (hburst == HBURST_SINGLE));
        w_arb_point  = hready && !w_owner_lock && (w_xfer_end || w_hold_full);
        w_next_idx   = w_pick_valid ? w_pick_idx : DEF_IDX;
    end

    // FSM, grant, pipeline owners, lock flag and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_PARK;
            r_hgrant       <= DEF_GRANT;
            r_hmaster      <= DEF_IDX;
            r_hmaster_data <= DEF_IDX;
            r_hmastlock    <= 1'b0;
            r_hold_cnt     <= '0;
        end else if (hready) begin
            r_hmaster      <= w_grant_idx;
            r_hmaster_data <= r_hmaster;
            r_hmastlock    <= w_owner_lock;

            // Any arbitration point restarts the hold window, even if the
            // owner keeps the bus because nobody else is asking.
            if (w_arb_point) begin
                r_hgrant   <= MASTERS'(1) << w_next_idx;
                r_hold_cnt <= '0;
            end else if (f_trans_active(w_htrans) && w_others_req && !w_hold_full) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            case (r_state)
                ST_PARK: begin
                    if (|hbusreq) begin
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_owner_lock) begin
                        r_state <= ST_LOCK;
                    end else if (w_arb_point && !w_pick_valid) begin
                        r_state <= ST_PARK;
                    end
                end
                ST_LOCK: begin
                    if (!w_owner_lock) begin
                        r_state <= ST_OWN;
                    end
                end
                default: r_state <= ST_PARK;
            endcase
        end
    end

    assign hgrant       = r_hgrant;
    assign hmaster      = r_hmaster;
    assign hmaster_data = r_hmaster_data;
    assign hmastlock    = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed and random bench for ahb_arbiter against a behavioural model.
module tb_ahb_arbiter;
    import ahb_arbiter_pkg::*;

    localparam int unsigned M    = 2;
    localparam int unsigned DEF  = 0;
    localparam int unsigned MAXH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [M-1:0]         hbusreq;
    logic [M-1:0]         hlock;
    logic [1:0]           htrans;
    logic [2:0]           hburst;
    logic                 hready;
    logic [M-1:0]         hgrant;
    logic [$clog2(M)-1:0] hmaster;
    logic [$clog2(M)-1:0] hmaster_data;
    logic                 hmastlock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: integer owner indices and a plain hold count
    int mg, mm, md, ml, mc;

    ahb_arbiter #(
        .MASTERS        (M),
        .DEFAULT_MASTER (DEF),
        .MAX_HOLD       (MAXH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hbusreq      (hbusreq),
        .hlock        (hlock),
        .htrans       (htrans),
        .hburst       (hburst),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the arbitration rules to the inputs about to be sampled
    task automatic model_edge();
        bit others, arb, found;
        int ng, c;
        if (rst) begin
            mg = DEF; mm = DEF; md = DEF; ml = 0; mc = 0;
            return;
        end
        if (!hready) return;
        others = 0;
        for (int i = 0; i < M; i++) if (hbusreq[i] && i != mg) others = 1;
        arb = !hlock[mg] && (htrans == 0 || (htrans == 2 && hburst == 0) || mc == MAXH);
        md = mm;
        mm = mg;
        ml = int'(hlock[mg]);
        if (arb) begin
            ng = DEF;
            found = 0;
            for (int k = 1; k <= M; k++) begin
                c = (mg + k) % M;
                if (!found && hbusreq[c]) begin
                    ng = c;
                    found = 1;
                end
            end
            mg = ng;
            mc = 0;
        end else if ((htrans == 2 || htrans == 3) && others && mc < MAXH) begin
            mc++;
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".hgrant"},       32'(hgrant),       32'(1 << mg));
        check({tag, ".onehot"},       32'($onehot(hgrant)), 32'd1);
        check({tag, ".hmaster"},      32'(hmaster),      32'(mm));
        check({tag, ".hmaster_data"}, 32'(hmaster_data), 32'(md));
        check({tag, ".hmastlock"},    32'(hmastlock),    32'(ml));
    endtask

    // Hand the grant to master m via an idle arbitration cycle
    task automatic idle_to(input int m);
        hbusreq = M'(1) << m;
        hlock   = '0;
        htrans  = HTRANS_IDLE;
        hburst  = HBURST_SINGLE;
        hready  = 1'b1;
        step("handto");
    endtask

    initial begin
        rst = 1'b1; hbusreq = '0; hlock = '0;
        htrans = HTRANS_IDLE; hburst = HBURST_SINGLE; hready = 1'b1;
        step("reset");
        step("reset");
        check("reset.state", 32'(dut.r_state), 32'(ST_PARK));

        // Parked with no requests
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("park");
            check("park.state", 32'(dut.r_state), 32'(ST_PARK));
        end

        // Round-robin with single transfers
        hbusreq = 2'b11; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
        for (int i = 0; i < 8; i++) step("rr");

        // INCR4 burst by M1 with M0 waiting
        idle_to(1);
        hbusreq = 2'b11; htrans = HTRANS_NONSEQ; hburst = HBURST_INCR4;
        step("burst");
        check("burst.hold0", 32'(hgrant), 32'(2'b10));
        htrans = HTRANS_SEQ;
        for (int i = 0; i < 3; i++) begin
            step("burst");
            check("burst.hold", 32'(hgrant), 32'(2'b10));
        end
        htrans = HTRANS_IDLE;
        step("burst.end");
        check("burst.switch", 32'(hgrant), 32'(2'b01));

        // Wait states during a handover
        hbusreq = 2'b11; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
        step("ws.pre");
        hready = 1'b0;
        for (int i = 0; i < 3; i++) step("ws.frozen");
        hready = 1'b1;
        step("ws.go");
        step("ws.go");

        // Locked burst by M0 ignores the hold limit
        idle_to(0);
        hbusreq = 2'b11; hlock = 2'b01; htrans = HTRANS_NONSEQ; hburst = HBURST_INCR;
        step("lock");
        htrans = HTRANS_SEQ;
        for (int i = 0; i < 20; i++) step("lock");
        check("lock.grant", 32'(hgrant), 32'(2'b01));
        check("lock.mastlock", 32'(hmastlock), 32'd1);
        check("lock.state", 32'(dut.r_state), 32'(ST_LOCK));
        hlock = 2'b00;
        step("lock.release");
        check("lock.release.grant", 32'(hgrant), 32'(2'b10));

        // Unlocked starvation limit
        idle_to(0);
        hbusreq = 2'b11; htrans = HTRANS_NONSEQ; hburst = HBURST_INCR;
        step("starve");
        htrans = HTRANS_SEQ;
        for (int i = 1; i < 16; i++) step("starve");
        check("starve.held16", 32'(hgrant), 32'(2'b01));
        step("starve.limit");
        check("starve.switch", 32'(hgrant), 32'(2'b10));

        // Reset in the middle of a locked burst
        idle_to(0);
        hbusreq = 2'b11; hlock = 2'b01; htrans = HTRANS_NONSEQ; hburst = HBURST_INCR;
        step("rlock");
        htrans = HTRANS_SEQ;
        step("rlock");
        step("rlock");
        check("rlock.state", 32'(dut.r_state), 32'(ST_LOCK));
        rst = 1'b1;
        step("rlock.rst");
        check("rlock.grant", 32'(hgrant), 32'(2'b01));
        check("rlock.mastlock", 32'(hmastlock), 32'd0);
        check("rlock.pstate", 32'(dut.r_state), 32'(ST_PARK));
        rst = 1'b0; hlock = '0; hbusreq = '0; htrans = HTRANS_IDLE;
        step("rlock.after");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            hready  = ($urandom_range(0, 3) != 0);
            hbusreq = M'($urandom);
            hlock   = ($urandom_range(0, 3) == 0) ? M'($urandom) : '0;
            htrans  = 2'($urandom);
            hburst  = ($urandom_range(0, 1) == 0) ? HBURST_SINGLE : 3'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
